// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo-style execution cluster: widths, null tag,
// ALU op encoding and the reservation-station entry record.
package tomasulo_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [TAG_W-1:0] NULL_TAG = '0;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        alu_op_e           op;
        logic              rdy1;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] val1;
        logic              rdy2;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val2;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-first arbiter: grants the requester that no other requester is older
// than, using an age matrix where age_i[i][j]=1 means i is older than j.
module rs_age_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0][N-1:0]  age_i,
    output logic [N-1:0]         grant_o,
    output logic [IDX_W-1:0]     idx_o
);

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < N; i++) begin
            grant_o[i] = req_i[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && req_i[j] && age_i[j][i]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/add_reservation_station.sv
// Reservation station for the integer add/sub unit: captures renamed ops,
// snoops the CDB for pending sources and issues the oldest ready entry.
module add_reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE    = 1,
    parameter int TAG_W       = tomasulo_pkg::TAG_W,
    parameter int DATA_W      = tomasulo_pkg::DATA_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             disp_valid,
    input  logic                             disp_op,
    input  logic                             disp_rs1_rdy,
    input  logic [TAG_W-1:0]                 disp_rs1_tag,
    input  logic [DATA_W-1:0]                disp_rs1_val,
    input  logic                             disp_rs2_rdy,
    input  logic [TAG_W-1:0]                 disp_rs2_tag,
    input  logic [DATA_W-1:0]                disp_rs2_val,
    output logic [TAG_W-1:0]                 add_available,
    output logic                             add_full,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy,
    input  logic                             cdb_valid,
    input  logic [TAG_W-1:0]                 cdb_tag,
    input  logic [DATA_W-1:0]                cdb_value,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [TAG_W-1:0]                 iss_tag,
    output logic                             iss_op,
    output logic [DATA_W-1:0]                iss_a,
    output logic [DATA_W-1:0]                iss_b
);
    import tomasulo_pkg::*;

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

    rs_entry_t                               ent_q [NUM_ENTRIES];
    rs_entry_t                               ent_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;
    logic                                    lock_q, lock_d;
    logic [IDX_W-1:0]                        lock_idx_q, lock_idx_d;

    logic [NUM_ENTRIES-1:0] valid_vec, ready_vec, grant;
    logic [IDX_W-1:0]       pick_idx, sel_idx, free_idx;
    logic                   disp_fire, iss_fire, cdb_hit;
    rs_entry_t              new_ent;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
        end
    end

    rs_age_picker #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_picker (
        .req_i   (ready_vec),
        .age_i   (age_q),
        .grant_o (grant),
        .idx_o   (pick_idx)
    );

    // Free-slot reporting looks only at registered state, so a slot freed by
    // issue this cycle is not offered to dispatch until the next one.
    always_comb begin
        free_idx  = '0;
        occupancy = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occupancy = occupancy + OCC_W'(valid_vec[i]);
        end
        add_full      = &valid_vec;
        add_available = add_full ? '0 : TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    end

    assign sel_idx   = lock_q ? lock_idx_q : pick_idx;
    assign iss_valid = lock_q || (|grant);
    assign iss_fire  = iss_valid && iss_ready;
    assign disp_fire = disp_valid && !add_full;
    assign cdb_hit   = cdb_valid && (cdb_tag != NULL_TAG);

    // A source whose producer broadcasts in the dispatch cycle is captured here.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.op    = alu_op_e'(disp_op);
        new_ent.tag1  = disp_rs1_tag;
        new_ent.tag2  = disp_rs2_tag;
        new_ent.rdy1  = disp_rs1_rdy || (cdb_hit && disp_rs1_tag == cdb_tag);
        new_ent.rdy2  = disp_rs2_rdy || (cdb_hit && disp_rs2_tag == cdb_tag);
        new_ent.val1  = disp_rs1_rdy ? disp_rs1_val : cdb_value;
        new_ent.val2  = disp_rs2_rdy ? disp_rs2_val : cdb_value;
    end

    always_comb begin
        ent_d = ent_q;
        age_d = age_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].valid && cdb_hit) begin
                if (!ent_q[i].rdy1 && ent_q[i].tag1 == cdb_tag) begin
                    ent_d[i].rdy1 = 1'b1;
                    ent_d[i].val1 = cdb_value;
                end
                if (!ent_q[i].rdy2 && ent_q[i].tag2 == cdb_tag) begin
                    ent_d[i].rdy2 = 1'b1;
                    ent_d[i].val2 = cdb_value;
                end
            end
        end
        if (iss_fire) ent_d[sel_idx].valid = 1'b0;
        if (disp_fire) begin
            ent_d[free_idx] = new_ent;
            for (int i = 0; i < NUM_ENTRIES; i++) age_d[i][free_idx] = 1'b1;
            age_d[free_idx] = '0;
        end
    end

    // Once offered, the grant is held until accepted so iss_* never changes
    // under a stalled adder, even if an older entry becomes ready meanwhile.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (iss_valid && !iss_ready) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end else if (iss_fire) begin
            lock_d = 1'b0;
        end
    end

    always_comb begin
        iss_tag = '0;
        iss_op  = 1'b0;
        iss_a   = '0;
        iss_b   = '0;
        if (iss_valid) begin
            iss_tag = TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
            iss_op  = ent_q[sel_idx].op;
            iss_a   = ent_q[sel_idx].val1;
            iss_b   = ent_q[sel_idx].val2;
        end
    end

    // NOTE: the entry array is a handful of flops, not a RAM, so it is reset
    // along with everything else; valid bits alone would not clear payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
            age_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
            age_q      <= age_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_add_reservation_station.sv
// Self-checking bench for add_reservation_station: a scoreboard of expected
// issues is compared at every accepted handshake, plus direct status checks.
module tb_add_reservation_station;

    typedef struct {
        logic [3:0]  tag;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid, disp_op;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [3:0]  disp_rs1_tag, disp_rs2_tag;
    logic [31:0] disp_rs1_val, disp_rs2_val;
    logic [3:0]  add_available;
    logic        add_full;
    logic [2:0]  occupancy;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iss_valid, iss_ready, iss_op;
    logic [3:0]  iss_tag;
    logic [31:0] iss_a, iss_b;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    add_reservation_station #(.NUM_ENTRIES(4), .TAG_BASE(1), .TAG_W(4), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_op       (disp_op),
        .disp_rs1_rdy  (disp_rs1_rdy),
        .disp_rs1_tag  (disp_rs1_tag),
        .disp_rs1_val  (disp_rs1_val),
        .disp_rs2_rdy  (disp_rs2_rdy),
        .disp_rs2_tag  (disp_rs2_tag),
        .disp_rs2_val  (disp_rs2_val),
        .add_available (add_available),
        .add_full      (add_full),
        .occupancy     (occupancy),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_tag       (iss_tag),
        .iss_op        (iss_op),
        .iss_a         (iss_a),
        .iss_b         (iss_b)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic dispatch(input logic op,
                            input logic r1_rdy, input logic [3:0] r1_tag, input logic [31:0] r1_val,
                            input logic r2_rdy, input logic [3:0] r2_tag, input logic [31:0] r2_val);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_rs1_rdy = r1_rdy;
        disp_rs1_tag = r1_tag;
        disp_rs1_val = r1_val;
        disp_rs2_rdy = r2_rdy;
        disp_rs2_tag = r2_tag;
        disp_rs2_val = r2_val;
    endtask

    task automatic broadcast(input logic v, input logic [3:0] tag, input logic [31:0] value);
        cdb_valid = v;
        cdb_tag   = tag;
        cdb_value = value;
    endtask

    task automatic push(input logic [3:0] tag, input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.tag = tag;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        sb_q.push_back(e);
    endtask

    // Every accepted issue must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && iss_valid && iss_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_issue_tag", 64'(iss_tag), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_tag", 64'(iss_tag), 64'(e.tag));
                check("sb_op",  64'(iss_op),  64'(e.op));
                check("sb_a",   64'(iss_a),   64'(e.a));
                check("sb_b",   64'(iss_b),   64'(e.b));
            end
        end
    end

    initial begin
        reset = 1'b1;
        disp_valid = 1'b0; disp_op = 1'b0;
        disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
        disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
        broadcast(1'b0, 4'd0, 32'd0);
        iss_ready = 1'b0;

        settle();
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_add_available", 64'(add_available), 64'd1);
        check("rst_add_full", 64'(add_full), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_iss_tag", 64'(iss_tag), 64'd0);
        tick();
        reset = 1'b0;

        // Both sources ready at dispatch: issue one cycle later.
        dispatch(1'b0, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
        push(4'd1, 1'b0, 32'd5, 32'd7);
        settle();
        check("t1_no_same_cycle_issue", 64'(iss_valid), 64'd0);
        tick();
        disp_valid = 1'b0;
        iss_ready  = 1'b1;
        settle();
        check("t1_iss_valid", 64'(iss_valid), 64'd1);
        check("t1_iss_tag", 64'(iss_tag), 64'd1);
        check("t1_occupancy", 64'(occupancy), 64'd1);
        check("t1_add_available", 64'(add_available), 64'd2);
        tick();
        iss_ready = 1'b0;
        settle();
        check("t1_freed_occupancy", 64'(occupancy), 64'd0);
        check("t1_freed_available", 64'(add_available), 64'd1);
        check("t1_idle", 64'(iss_valid), 64'd0);

        // rs1 waits on tag 6; a broadcast of tag 7 must be ignored.
        tick();
        dispatch(1'b1, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd3);
        push(4'd1, 1'b1, 32'h100, 32'd3);
        tick();
        disp_valid = 1'b0;
        settle();
        check("t2_wait", 64'(iss_valid), 64'd0);
        tick();
        broadcast(1'b1, 4'd7, 32'hdead);
        settle();
        check("t2_wait_tag7", 64'(iss_valid), 64'd0);
        tick();
        broadcast(1'b1, 4'd6, 32'h100);
        settle();
        check("t2_cdb_cycle", 64'(iss_valid), 64'd0);
        tick();
        broadcast(1'b0, 4'd0, 32'd0);
        iss_ready = 1'b1;
        settle();
        check("t2_after_cdb", 64'(iss_valid), 64'd1);
        check("t2_iss_a", 64'(iss_a), 64'h100);
        tick();
        iss_ready = 1'b0;

        // Dispatch/CDB bypass on rs2.
        dispatch(1'b0, 1'b1, 4'd0, 32'd2, 1'b0, 4'd6, 32'd0);
        broadcast(1'b1, 4'd6, 32'd9);
        push(4'd1, 1'b0, 32'd2, 32'd9);
        tick();
        disp_valid = 1'b0;
        broadcast(1'b0, 4'd0, 32'd0);
        iss_ready = 1'b1;
        settle();
        check("t3_bypass_valid", 64'(iss_valid), 64'd1);
        check("t3_bypass_b", 64'(iss_b), 64'd9);
        tick();
        iss_ready = 1'b0;

        // Fill all entries with pending sources, then attempt a fifth dispatch.
        for (int k = 0; k < 4; k++) begin
            dispatch(1'(k), 1'b0, 4'(10 + k), 32'd0, 1'b1, 4'd0, 32'(32'h20 + k));
            settle();
            check("t4_fill_available", 64'(add_available), 64'(k + 1));
            tick();
        end
        dispatch(1'b0, 1'b1, 4'd0, 32'h55, 1'b1, 4'd0, 32'h66);
        settle();
        check("t4_full", 64'(add_full), 64'd1);
        check("t4_full_available", 64'(add_available), 64'd0);
        check("t4_full_occupancy", 64'(occupancy), 64'd4);
        tick();
        disp_valid = 1'b0;
        settle();
        check("t4_drop_occupancy", 64'(occupancy), 64'd4);
        check("t4_drop_no_issue", 64'(iss_valid), 64'd0);

        // Resolve youngest first with the adder always ready: issue order 4,3,2,1.
        for (int k = 3; k >= 0; k--) begin
            push(4'(k + 1), 1'(k), 32'(32'h1000 + k), 32'(32'h20 + k));
        end
        tick();
        iss_ready = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            broadcast(1'b1, 4'(10 + k), 32'(32'h1000 + k));
            tick();
        end
        broadcast(1'b0, 4'd0, 32'd0);
        settle();
        tick();
        iss_ready = 1'b0;
        settle();
        check("t4_drained_occupancy", 64'(occupancy), 64'd0);
        check("t4_drained_full", 64'(add_full), 64'd0);

        // Lock: B becomes ready first, then older A; B must stay on iss_* until accepted.
        tick();
        dispatch(1'b0, 1'b0, 4'd10, 32'd0, 1'b1, 4'd0, 32'd1);
        tick();
        dispatch(1'b1, 1'b0, 4'd11, 32'd0, 1'b1, 4'd0, 32'd2);
        tick();
        disp_valid = 1'b0;
        broadcast(1'b1, 4'd11, 32'hB0);
        tick();
        broadcast(1'b1, 4'd10, 32'hA0);
        settle();
        check("t5_b_first", 64'(iss_tag), 64'd2);
        tick();
        broadcast(1'b0, 4'd0, 32'd0);
        settle();
        check("t5_locked_tag", 64'(iss_tag), 64'd2);
        check("t5_locked_a", 64'(iss_a), 64'hB0);
        tick();
        settle();
        check("t5_still_locked", 64'(iss_tag), 64'd2);
        push(4'd2, 1'b1, 32'hB0, 32'd2);
        push(4'd1, 1'b0, 32'hA0, 32'd1);
        tick();
        iss_ready = 1'b1;
        settle();
        tick();
        settle();
        check("t5_then_a", 64'(iss_tag), 64'd1);
        tick();
        iss_ready = 1'b0;
        settle();
        check("t5_done", 64'(iss_valid), 64'd0);

        // Reset asserted while an issue is stalled.
        tick();
        dispatch(1'b0, 1'b1, 4'd0, 32'd11, 1'b1, 4'd0, 32'd22);
        tick();
        disp_valid = 1'b0;
        settle();
        check("t6_pending", 64'(iss_valid), 64'd1);
        tick();
        reset = 1'b1;
        #1;
        check("t6_rst_iss_valid", 64'(iss_valid), 64'd0);
        check("t6_rst_available", 64'(add_available), 64'd1);
        check("t6_rst_occupancy", 64'(occupancy), 64'd0);
        tick();
        reset = 1'b0;
        settle();
        check("t6_lost", 64'(iss_valid), 64'd0);

        check("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
